// File: rtl/pwr_seq_pkg.sv
// Purpose: shared types, default timing and output decode for the per-domain power sequencer.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package pwr_seq_pkg;

  typedef enum logic [3:0] {
    S_OFF     = 4'd0,
    S_PSW_ON  = 4'd1,
    S_RST     = 4'd2,
    S_RESTORE = 4'd3,
    S_DE_ISO  = 4'd4,
    S_CLK_ON  = 4'd5,
    S_ON      = 4'd6,
    S_CLK_OFF = 4'd7,
    S_ISO     = 4'd8,
    S_SAVE    = 4'd9,
    S_PSW_OFF = 4'd10
  } pwr_seq_state_t;

  localparam int DEF_CNT_W         = 8;
  localparam int DEF_ISO_SETUP_CYC = 2;
  localparam int DEF_RST_HOLD_CYC  = 4;
  localparam int DEF_PSW_TIMEOUT   = 64;

  // Domain control bundle, one bit per physical control.
  typedef struct packed {
    logic pwr_on;
    logic iso_en;
    logic clk_en;
    logic dom_rst;
    logic ret_save;
    logic ret_restore;
  } pwr_ctl_t;

  // Safe-off values: rail off, clamped, clock gated, domain held in reset.
  localparam pwr_ctl_t CTL_SAFE_OFF = '{pwr_on: 1'b0, iso_en: 1'b1, clk_en: 1'b0,
                                        dom_rst: 1'b1, ret_save: 1'b0, ret_restore: 1'b0};

  // Control values held while the sequencer sits in a given state.
  function automatic pwr_ctl_t ctl_decode(pwr_seq_state_t s);
    pwr_ctl_t c;
    c = CTL_SAFE_OFF;
    case (s)
      S_PSW_ON, S_RST: begin c.pwr_on = 1'b1; end
      S_RESTORE:       begin c.pwr_on = 1'b1; c.dom_rst = 1'b0; c.ret_restore = 1'b1; end
      S_DE_ISO,
      S_CLK_OFF:       begin c.pwr_on = 1'b1; c.iso_en = 1'b0; c.dom_rst = 1'b0; end
      S_CLK_ON, S_ON:  begin c.pwr_on = 1'b1; c.iso_en = 1'b0; c.dom_rst = 1'b0; c.clk_en = 1'b1; end
      S_ISO:           begin c.pwr_on = 1'b1; c.dom_rst = 1'b0; end
      S_SAVE:          begin c.pwr_on = 1'b1; c.dom_rst = 1'b0; c.ret_save = 1'b1; end
      S_PSW_OFF:       begin c.dom_rst = 1'b0; end
      default:         c = CTL_SAFE_OFF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// Purpose: loadable down-counter shared by the hold waits and the power-switch ack timeout.
// Latency: expired is high once the count has reached zero (load value N gives N+1 cycles).
// Backpressure: none; load has priority over counting.
module pwr_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/pwr_domain_seq_ctrl.sv
// Purpose: per-domain power sequencer turning PMU on/off requests into ordered clock/iso/retention/switch/reset steps.
// Latency: outputs registered from the next state; done pulses in the first cycle of S_ON/S_OFF.
// Backpressure: req_ready only in S_ON/S_OFF; requests seen while busy are ignored. Macro: PWR_SEQ_RETENTION_EN.
module pwr_domain_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int ISO_SETUP_CYC = DEF_ISO_SETUP_CYC,
  parameter int RST_HOLD_CYC  = DEF_RST_HOLD_CYC,
  parameter int PSW_TIMEOUT   = DEF_PSW_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_on,
  output logic       req_ready,
  input  logic       psw_ack,
  output logic       pwr_on,
  output logic       iso_en,
  output logic       clk_en,
  output logic       dom_rst,
  output logic       ret_save,
  output logic       ret_restore,
  output logic       done,
  output logic       err,
  output logic [3:0] state
);

`ifdef PWR_SEQ_RETENTION_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LD_TMO = CNT_W'(PSW_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LD_ISO = CNT_W'(ISO_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_RST = CNT_W'(RST_HOLD_CYC - 1);

  pwr_seq_state_t   cur_state, nxt_state;
  pwr_ctl_t         ctl_q, nxt_ctl;
  logic             ack_s1, ack_s2;
  logic             tmr_load, tmr_exp;
  logic [CNT_W-1:0] tmr_val;
  logic             accept, seq_done, timeout;

  // Two-flop synchroniser for the asynchronous rail-good status.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      ack_s1 <= psw_ack;
      ack_s2 <= ack_s1;
    end
  end

  pwr_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  // State register plus registered outputs, done pulse and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_OFF;
      ctl_q     <= CTL_SAFE_OFF;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      ctl_q     <= nxt_ctl;
      done      <= seq_done;
      if (timeout) begin
        err <= 1'b1;
      end else if (accept) begin
        err <= 1'b0;
      end
    end
  end

  // Next-state logic; also arms the shared timer on entry to a timed state.
  always_comb begin
    nxt_state = cur_state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    accept    = 1'b0;
    seq_done  = 1'b0;
    timeout   = 1'b0;
    case (cur_state)
      S_OFF: if (req_valid) begin
        accept = 1'b1;
        if (req_on) begin
          nxt_state = S_PSW_ON;
          tmr_load  = 1'b1;
          tmr_val   = LD_TMO;
        end else begin
          seq_done = 1'b1;
        end
      end
      S_ON: if (req_valid) begin
        accept = 1'b1;
        if (!req_on) begin
          nxt_state = S_CLK_OFF;
        end else begin
          seq_done = 1'b1;
        end
      end
      // Ack beats a simultaneous timeout.
      S_PSW_ON: if (ack_s2) begin
        nxt_state = S_RST;
        tmr_load  = 1'b1;
        tmr_val   = LD_RST;
      end else if (tmr_exp) begin
        nxt_state = S_OFF;
        timeout   = 1'b1;
      end
      S_RST:     if (tmr_exp) nxt_state = RET_EN ? S_RESTORE : S_DE_ISO;
      S_RESTORE: nxt_state = S_DE_ISO;
      S_DE_ISO:  nxt_state = S_CLK_ON;
      S_CLK_ON: begin
        nxt_state = S_ON;
        seq_done  = 1'b1;
      end
      S_CLK_OFF: begin
        nxt_state = S_ISO;
        tmr_load  = 1'b1;
        tmr_val   = LD_ISO;
      end
      S_ISO: if (tmr_exp) begin
        if (RET_EN) begin
          nxt_state = S_SAVE;
        end else begin
          nxt_state = S_PSW_OFF;
          tmr_load  = 1'b1;
          tmr_val   = LD_TMO;
        end
      end
      S_SAVE: begin
        nxt_state = S_PSW_OFF;
        tmr_load  = 1'b1;
        tmr_val   = LD_TMO;
      end
      S_PSW_OFF: if (!ack_s2) begin
        nxt_state = S_OFF;
        seq_done  = 1'b1;
      end else if (tmr_exp) begin
        nxt_state = S_OFF;
        timeout   = 1'b1;
      end
      default: nxt_state = S_OFF;
    endcase
  end

  // Output decode from the next state so the registered controls track the state register.
  always_comb begin
    nxt_ctl             = ctl_decode(nxt_state);
    nxt_ctl.ret_save    = nxt_ctl.ret_save & RET_EN;
    nxt_ctl.ret_restore = nxt_ctl.ret_restore & RET_EN;
  end

  assign req_ready   = (cur_state == S_ON) || (cur_state == S_OFF);
  assign pwr_on      = ctl_q.pwr_on;
  assign iso_en      = ctl_q.iso_en;
  assign clk_en      = ctl_q.clk_en;
  assign dom_rst     = ctl_q.dom_rst;
  assign ret_save    = ctl_q.ret_save;
  assign ret_restore = ctl_q.ret_restore;
  assign state       = cur_state;

endmodule
